// File: rtl/adder_n_bit.sv
// Registered unsigned N-bit adder: full-width (N+1)-bit sum, carry-out in the MSB,
// one output register stage qualified by out_valid.
module adder_n_bit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         in_valid,
  output logic [N:0]   sum,
  output logic         out_valid
);

  if (N < 1 || N > 64) begin : g_bad_n
    $error("adder_n_bit: N must be in 1..64");
  end

  logic [N:0] sum_next;

  // Operands are zero-extended before the add, so the carry lands in bit N and nothing wraps.
  assign sum_next = {1'b0, a} + {1'b0, b};

  // Handshake: a pair is taken on every rising edge where in_valid=1 (no ready, no backpressure).
  // out_valid is high for exactly the cycle after such an edge.
  // sum keeps its last result otherwise, so a/b are don't-care while in_valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) sum <= sum_next;
    end
  end

endmodule

// File: tb/tb_adder_n_bit.sv
// Bench for adder_n_bit: four widths (8, 1, 16, 64) driven in lockstep, with a queue-based
// scoreboard per width and a reference sum computed at 65 bits.
module tb_adder_n_bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a8 = '0, b8 = '0;
  logic [0:0]  a1 = '0, b1 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [63:0] a64 = '0, b64 = '0;
  logic v8 = 1'b0, v1 = 1'b0, v16 = 1'b0, v64 = 1'b0;
  logic [8:0]  sum8;
  logic [1:0]  sum1;
  logic [16:0] sum16;
  logic [64:0] sum64;
  logic ov8, ov1, ov16, ov64;

  adder_n_bit #(.N(8))  u_n8  (.clk(clk), .rst_n(rst_n), .a(a8),  .b(b8),  .in_valid(v8),  .sum(sum8),  .out_valid(ov8));
  adder_n_bit #(.N(1))  u_n1  (.clk(clk), .rst_n(rst_n), .a(a1),  .b(b1),  .in_valid(v1),  .sum(sum1),  .out_valid(ov1));
  adder_n_bit #(.N(16)) u_n16 (.clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .in_valid(v16), .sum(sum16), .out_valid(ov16));
  adder_n_bit #(.N(64)) u_n64 (.clk(clk), .rst_n(rst_n), .a(a64), .b(b64), .in_valid(v64), .sum(sum64), .out_valid(ov64));

  logic [64:0] exp_q8[$], exp_q1[$], exp_q16[$], exp_q64[$];
  logic [64:0] hold8 = '0, hold1 = '0, hold16 = '0, hold64 = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: out_valid high with no pending operand pair (t=%0t)", name, $time);
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge; expected sums are queued on issue.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put8(input logic [7:0] x, input logic [7:0] y, input logic v);
    a8 = x; b8 = y; v8 = v;
    if (v) exp_q8.push_back(65'(x) + 65'(y));
  endtask

  task automatic put1(input logic [0:0] x, input logic [0:0] y, input logic v);
    a1 = x; b1 = y; v1 = v;
    if (v) exp_q1.push_back(65'(x) + 65'(y));
  endtask

  task automatic put16(input logic [15:0] x, input logic [15:0] y, input logic v);
    a16 = x; b16 = y; v16 = v;
    if (v) exp_q16.push_back(65'(x) + 65'(y));
  endtask

  task automatic put64(input logic [63:0] x, input logic [63:0] y, input logic v);
    a64 = x; b64 = y; v64 = v;
    if (v) exp_q64.push_back(65'(x) + 65'(y));
  endtask

  task automatic rnd_others();
    put1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    put16(16'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
    put64({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
  endtask

  task automatic s8(input logic [7:0] x, input logic [7:0] y, input logic v);
    tick();
    put8(x, y, v);
    rnd_others();
  endtask

  task automatic flush_model();
    exp_q8.delete(); exp_q1.delete(); exp_q16.delete(); exp_q64.delete();
    hold8 = '0; hold1 = '0; hold16 = '0; hold64 = '0;
  endtask

  task automatic fresh_pairs();
    put8(8'($urandom), 8'($urandom), 1'b1);
    put1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    put16(16'($urandom), 16'($urandom), 1'b1);
    put64({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
  endtask

  // Reset pulse entirely between two edges, with a fresh valid pair waiting at release.
  task automatic mid_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum8", 65'(sum8), 65'd0);
    chk("mid_rst_ov8", 65'(ov8), 65'd0);
    chk("mid_rst_sum64", sum64, 65'd0);
    chk("mid_rst_ov64", 65'(ov64), 65'd0);
    flush_model();
    fresh_pairs();
    #1 rst_n = 1'b1;
  endtask

  // Reset held across a rising edge with in_valid=1: that pair must never appear.
  task automatic reset_over_edge();
    rst_n = 1'b0;
    fresh_pairs();
    tick();
    flush_model();
    fresh_pairs();
    rst_n = 1'b1;
  endtask

  // Monitors: sample on the falling edge, pop on out_valid, otherwise require the held value.
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_sum8", 65'(sum8), 65'd0);
        chk("rst_ov8", 65'(ov8), 65'd0);
      end else if (ov8) begin
        if (exp_q8.size() == 0) bad("extra_valid8");
        else begin
          e = exp_q8.pop_front();
          chk("sum8", 65'(sum8), e);
          hold8 = e;
        end
      end else chk("hold8", 65'(sum8), hold8);
    end
  end

  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) chk("rst_sum1", 65'(sum1), 65'd0);
      else if (ov1) begin
        if (exp_q1.size() == 0) bad("extra_valid1");
        else begin
          e = exp_q1.pop_front();
          chk("sum1", 65'(sum1), e);
          hold1 = e;
        end
      end else chk("hold1", 65'(sum1), hold1);
    end
  end

  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) chk("rst_sum16", 65'(sum16), 65'd0);
      else if (ov16) begin
        if (exp_q16.size() == 0) bad("extra_valid16");
        else begin
          e = exp_q16.pop_front();
          chk("sum16", 65'(sum16), e);
          hold16 = e;
        end
      end else chk("hold16", 65'(sum16), hold16);
    end
  end

  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) chk("rst_sum64", sum64, 65'd0);
      else if (ov64) begin
        if (exp_q64.size() == 0) bad("extra_valid64");
        else begin
          e = exp_q64.pop_front();
          chk("sum64", sum64, e);
          hold64 = e;
        end
      end else chk("hold64", sum64, hold64);
    end
  end

  // Stimulus
  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    s8(8'd0, 8'd0, 1'b1);
    s8(8'd1, 8'd99, 1'b1);
    s8(8'd33, 8'd66, 1'b1);
    s8(8'd100, 8'd47, 1'b1);
    s8(8'd255, 8'd255, 1'b1);
    s8(8'd128, 8'd128, 1'b1);
    s8(8'd255, 8'd1, 1'b1);
    s8(8'd254, 8'd1, 1'b1);

    s8(8'd10, 8'd20, 1'b1);
    repeat (3) s8(8'd7, 8'd7, 1'b0);

    tick();
    put8(8'($urandom), 8'($urandom), 1'b1);
    put1(1'b1, 1'b1, 1'b1);
    put16(16'hFFFF, 16'hFFFF, 1'b1);
    put64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    repeat (150) s8(8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);

    s8(8'd200, 8'd100, 1'b1);
    s8(8'd50, 8'd60, 1'b1);
    mid_reset();
    repeat (20) s8(8'($urandom), 8'($urandom), 1'b1);

    tick();
    reset_over_edge();
    repeat (20) s8(8'($urandom), 8'($urandom), $urandom_range(0, 1) != 0);

    tick();
    put8(8'd0, 8'd0, 1'b0);
    put1(1'b0, 1'b0, 1'b0);
    put16(16'd0, 16'd0, 1'b0);
    put64(64'd0, 64'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("drained_q8", 65'(exp_q8.size()), 65'd0);
    chk("drained_q1", 65'(exp_q1.size()), 65'd0);
    chk("drained_q16", 65'(exp_q16.size()), 65'd0);
    chk("drained_q64", 65'(exp_q64.size()), 65'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
